// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage IF/ID/EX/MEM/WB core.
// Generates per-register stall/flush, services exceptions and control ops seen
// on the MEM/WB register, redirects fetch, and holds EPC/cause/int_en/int_mask.
// Optional build macro: XSOC_IRQ_EN enables the irq synchronizer, the
// interrupt mask register and int_detect; without it int_mask reads 8'hFF and
// int_detect is tied low.
module pipe_ctrl #(
  parameter logic [29:0] RESET_VECTOR = 30'h0,
  parameter logic [29:0] EXC_VECTOR   = 30'h4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        ld_hazard,
  input  logic [29:0] mem_pc,
  input  logic        mem_en,
  input  logic        mem_br_flag,
  input  logic [1:0]  mem_ctrl_op,
  input  logic [4:0]  mem_dst_addr,
  input  logic [2:0]  mem_exp_code,
  input  logic [31:0] mem_out,
  input  logic [7:0]  irq,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic [29:0] new_pc,
  output logic        int_detect,
  output logic [29:0] epc,
  output logic [2:0]  exp_code,
  output logic        int_en,
  output logic [7:0]  int_mask
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [1:0] OP_WRCR     = 2'd1;
  localparam logic [1:0] OP_EXRT     = 2'd2;
  localparam logic [4:0] CR_INT_EN   = 5'd0;
  localparam logic [4:0] CR_INT_MASK = 5'd1;

  // Restart address: a faulting delay-slot instruction restarts at its branch.
  function automatic logic [29:0] restart_pc(input logic [29:0] pc,
                                             input logic        in_slot);
    return in_slot ? (pc - 30'd1) : pc;
  endfunction

  state_t      state;
  logic        pre_int_en;
  logic        busy;
  logic        run_act;
  logic        exc_take;
  logic        exrt_take;
  logic        wrcr_take;
  logic [3:0]  stall_v;   // {if, id, ex, mem}
  logic [3:0]  flush_v;   // {if, id, ex, mem}

  assign busy      = if_busy | mem_busy;
  assign run_act   = (state == RUN) && !busy;
  assign exc_take  = run_act && mem_en && (mem_exp_code != 3'd0);
  assign exrt_take = run_act && mem_en && !exc_take && (mem_ctrl_op == OP_EXRT);
  assign wrcr_take = run_act && mem_en && !exc_take && (mem_ctrl_op == OP_WRCR);

  // Stall/flush/redirect decode in priority order; WRCR itself never
  // touches the pipeline, so a load-use hazard alongside it is still honoured.
  always_comb begin
    stall_v = 4'b0000;
    flush_v = 4'b0000;
    new_pc  = 30'h0;
    if (state == BOOT) begin
      flush_v = 4'b1111;
      new_pc  = RESET_VECTOR;
    end else if (busy) begin
      stall_v = 4'b1111;
    end else if (exc_take) begin
      flush_v = 4'b1111;
      new_pc  = EXC_VECTOR;
    end else if (exrt_take) begin
      flush_v = 4'b1111;
      new_pc  = epc;
    end else if (ld_hazard) begin
      stall_v = 4'b1100;
      flush_v = 4'b0100;
    end
  end

  assign {if_stall, id_stall, ex_stall, mem_stall} = stall_v;
  assign {if_flush, id_flush, ex_flush, mem_flush} = flush_v;

  // BOOT lasts exactly one cycle after reset, then RUN forever.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= RUN;
  end

  // Exception and interrupt-enable control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc        <= 30'h0;
      exp_code   <= 3'd0;
      int_en     <= 1'b0;
      pre_int_en <= 1'b0;
    end else if (exc_take) begin
      exp_code   <= mem_exp_code;
      epc        <= restart_pc(mem_pc, mem_br_flag);
      pre_int_en <= int_en;
      int_en     <= 1'b0;
    end else if (exrt_take) begin
      int_en     <= pre_int_en;
    end else if (wrcr_take && (mem_dst_addr == CR_INT_EN)) begin
      int_en     <= mem_out[0];
    end
  end

`ifdef XSOC_IRQ_EN
  logic [7:0] irq_sync_p0;
  logic [7:0] irq_sync_p1;
  logic       unused_data;

  assign unused_data = ^mem_out[31:8];

  // Two-flop synchronizer for the asynchronous interrupt lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_sync_p0 <= 8'h00;
      irq_sync_p1 <= 8'h00;
    end else begin
      irq_sync_p0 <= irq;
      irq_sync_p1 <= irq_sync_p0;
    end
  end

  // Interrupt mask register, written by WRCR to index 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_mask <= 8'hFF;
    end else if (wrcr_take && (mem_dst_addr == CR_INT_MASK)) begin
      int_mask <= mem_out[7:0];
    end
  end

  assign int_detect = int_en && (|(irq_sync_p1 & ~int_mask));
`else
  logic unused_data;

  assign unused_data = ^{mem_out[31:1], irq, CR_INT_MASK};
  assign int_mask    = 8'hFF;
  assign int_detect  = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl (default parameters). Inputs change just
// after the falling edge; outputs are sampled 1ns later, well before the next
// rising edge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_busy, mem_busy, ld_hazard;
  logic [29:0] mem_pc;
  logic        mem_en, mem_br_flag;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;
  logic [7:0]  irq;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic [29:0] new_pc;
  logic        int_detect;
  logic [29:0] epc;
  logic [2:0]  exp_code;
  logic        int_en;
  logic [7:0]  int_mask;

  logic [3:0]  stalls, flushes;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign stalls  = {if_stall, id_stall, ex_stall, mem_stall};
  assign flushes = {if_flush, id_flush, ex_flush, mem_flush};

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
    .ld_hazard(ld_hazard), .mem_pc(mem_pc), .mem_en(mem_en),
    .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_exp_code(mem_exp_code),
    .mem_out(mem_out), .irq(irq),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush),
    .ex_flush(ex_flush), .mem_flush(mem_flush), .new_pc(new_pc),
    .int_detect(int_detect), .epc(epc), .exp_code(exp_code),
    .int_en(int_en), .int_mask(int_mask)
  );

  // Return all stimulus inputs (except reset and irq) to idle.
  task automatic idle();
    if_busy = 0; mem_busy = 0; ld_hazard = 0;
    mem_pc = '0; mem_en = 0; mem_br_flag = 0; mem_ctrl_op = 2'd0;
    mem_dst_addr = 5'd0; mem_exp_code = 3'd0; mem_out = 32'h0;
  endtask

  // Drive one WRCR for a single cycle (no checks here).
  task automatic drive_wrcr(input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    idle(); mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = idx; mem_out = data;
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    reset = 1; irq = 8'h00; idle();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (flushes !== 4'hF) begin n_bad++; $display("FAIL rst_flush got %h want f", flushes); end
    n_cmp++; if (stalls !== 4'h0) begin n_bad++; $display("FAIL rst_stall got %h want 0", stalls); end
    n_cmp++; if (new_pc !== 30'h0) begin n_bad++; $display("FAIL rst_new_pc got %h want 0", new_pc); end
    n_cmp++; if ({epc, exp_code, int_en, int_detect} !== 35'h0) begin n_bad++; $display("FAIL rst_regs epc=%h code=%h en=%b det=%b want 0", epc, exp_code, int_en, int_detect); end
    n_cmp++; if (int_mask !== 8'hFF) begin n_bad++; $display("FAIL rst_mask got %h want ff", int_mask); end
    @(negedge clk);
    reset = 0; mem_busy = 1;   // BOOT ignores busy
    #1;
    n_cmp++; if (flushes !== 4'hF || stalls !== 4'h0) begin n_bad++; $display("FAIL boot_ctrl flush=%h stall=%h want f/0", flushes, stalls); end
    n_cmp++; if (new_pc !== 30'h0) begin n_bad++; $display("FAIL boot_new_pc got %h want 0", new_pc); end
    @(negedge clk);
    idle(); #1;
    n_cmp++; if ({stalls, flushes} !== 8'h00 || new_pc !== 30'h0) begin n_bad++; $display("FAIL run_idle stall=%h flush=%h pc=%h want 0", stalls, flushes, new_pc); end
  endtask

  task automatic test_wrcr();
    @(negedge clk);
    mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd0; mem_out = 32'h1;
    #1;
    n_cmp++; if ({stalls, flushes} !== 8'h00 || new_pc !== 30'h0) begin n_bad++; $display("FAIL wrcr_noflush stall=%h flush=%h pc=%h", stalls, flushes, new_pc); end
    @(negedge clk);
    idle(); #1;
    n_cmp++; if (int_en !== 1'b1) begin n_bad++; $display("FAIL wrcr_int_en got %b want 1", int_en); end
    drive_wrcr(5'd2, 32'h0);   // unused index: ignored
    #1;
    n_cmp++; if (int_en !== 1'b1) begin n_bad++; $display("FAIL wrcr_idx2 int_en got %b want 1", int_en); end
    @(negedge clk);
    mem_en = 0; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd0; mem_out = 32'h0;   // not valid
    @(negedge clk);
    idle(); #1;
    n_cmp++; if (int_en !== 1'b1) begin n_bad++; $display("FAIL wrcr_invalid int_en got %b want 1", int_en); end
  endtask

  task automatic test_busy_exception();
    @(negedge clk);
    mem_en = 1; mem_exp_code = 3'd3; mem_pc = 30'h80; mem_br_flag = 0; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (stalls !== 4'hF || flushes !== 4'h0 || new_pc !== 30'h0) begin n_bad++; $display("FAIL busy_ctrl[%0d] stall=%h flush=%h pc=%h want f/0/0", i, stalls, flushes, new_pc); end
      @(negedge clk);
      #1;
      n_cmp++; if (epc !== 30'h0 || int_en !== 1'b1 || exp_code !== 3'd0) begin n_bad++; $display("FAIL busy_hold[%0d] epc=%h en=%b code=%h want 0/1/0", i, epc, int_en, exp_code); end
    end
    mem_busy = 0; #1;
    n_cmp++; if (flushes !== 4'hF || stalls !== 4'h0 || new_pc !== 30'h4) begin n_bad++; $display("FAIL busy_exc_take flush=%h stall=%h pc=%h want f/0/4", flushes, stalls, new_pc); end
    @(negedge clk);
    idle(); #1;
    n_cmp++; if (epc !== 30'h80 || exp_code !== 3'd3 || int_en !== 1'b0) begin n_bad++; $display("FAIL busy_exc_regs epc=%h code=%h en=%b want 80/3/0", epc, exp_code, int_en); end
  endtask

  task automatic test_exception();
    drive_wrcr(5'd0, 32'h1);
    @(negedge clk);
    mem_en = 1; mem_exp_code = 3'd4; mem_pc = 30'h40; mem_br_flag = 1; mem_ctrl_op = 2'd1;
    #1;
    n_cmp++; if (flushes !== 4'hF || stalls !== 4'h0 || new_pc !== 30'h4) begin n_bad++; $display("FAIL exc_ctrl flush=%h stall=%h pc=%h want f/0/4", flushes, stalls, new_pc); end
    @(negedge clk);
    idle(); #1;
    n_cmp++; if (epc !== 30'h3F || exp_code !== 3'd4 || int_en !== 1'b0) begin n_bad++; $display("FAIL exc_regs epc=%h code=%h en=%b want 3f/4/0", epc, exp_code, int_en); end
  endtask

  task automatic test_exrt();
    @(negedge clk);
    mem_en = 1; mem_ctrl_op = 2'd2; ld_hazard = 1;
    #1;
    n_cmp++; if (flushes !== 4'hF || stalls !== 4'h0 || new_pc !== 30'h3F) begin n_bad++; $display("FAIL exrt_ctrl flush=%h stall=%h pc=%h want f/0/3f", flushes, stalls, new_pc); end
    @(negedge clk);
    idle(); #1;
    n_cmp++; if (int_en !== 1'b1 || epc !== 30'h3F) begin n_bad++; $display("FAIL exrt_regs en=%b epc=%h want 1/3f", int_en, epc); end
  endtask

  task automatic test_ld_hazard();
    @(negedge clk);
    ld_hazard = 1; #1;
    n_cmp++; if (stalls !== 4'b1100 || flushes !== 4'b0100 || new_pc !== 30'h0) begin n_bad++; $display("FAIL ldh_ctrl stall=%h flush=%h pc=%h want c/4/0", stalls, flushes, new_pc); end
    if_busy = 1; #1;
    n_cmp++; if (stalls !== 4'hF || flushes !== 4'h0) begin n_bad++; $display("FAIL ldh_busy stall=%h flush=%h want f/0", stalls, flushes); end
    // Exception with ld_hazard, delay slot at pc 0: epc wraps to all ones.
    if_busy = 0; mem_en = 1; mem_exp_code = 3'd6; mem_pc = 30'h0; mem_br_flag = 1;
    #1;
    n_cmp++; if (stalls !== 4'h0 || flushes !== 4'hF || new_pc !== 30'h4) begin n_bad++; $display("FAIL ldh_exc stall=%h flush=%h pc=%h want 0/f/4", stalls, flushes, new_pc); end
    @(negedge clk);
    idle(); #1;
    n_cmp++; if (epc !== 30'h3FFFFFFF || exp_code !== 3'd6 || int_en !== 1'b0) begin n_bad++; $display("FAIL epc_wrap epc=%h code=%h en=%b want 3fffffff/6/0", epc, exp_code, int_en); end
  endtask

  task automatic test_irq();
    logic [7:0] mask_exp;
    logic       det_exp;
`ifdef XSOC_IRQ_EN
    mask_exp = 8'hFE; det_exp = 1'b1;
`else
    mask_exp = 8'hFF; det_exp = 1'b0;
`endif
    drive_wrcr(5'd0, 32'h1);
    drive_wrcr(5'd1, 32'hFE);
    #1;
    n_cmp++; if (int_mask !== mask_exp) begin n_bad++; $display("FAIL irq_mask got %h want %h", int_mask, mask_exp); end
    irq = 8'h01;
    @(negedge clk); #1;
    n_cmp++; if (int_detect !== 1'b0) begin n_bad++; $display("FAIL irq_det_1edge got %b want 0", int_detect); end
    @(negedge clk); #1;
    n_cmp++; if (int_detect !== det_exp) begin n_bad++; $display("FAIL irq_det_2edge got %b want %b", int_detect, det_exp); end
    irq = 8'h00;
    repeat (2) @(negedge clk);
    irq = 8'h02;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (int_detect !== 1'b0) begin n_bad++; $display("FAIL irq_masked got %b want 0", int_detect); end
    irq = 8'h00;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    mem_en = 1; mem_exp_code = 3'd2; mem_pc = 30'h123;
    #2 reset = 1;
    #1;
    n_cmp++; if (flushes !== 4'hF || stalls !== 4'h0 || new_pc !== 30'h0 || int_detect !== 1'b0) begin n_bad++; $display("FAIL midrst_ctrl flush=%h stall=%h pc=%h det=%b", flushes, stalls, new_pc, int_detect); end
    @(negedge clk); #1;
    n_cmp++; if (epc !== 30'h0 || exp_code !== 3'd0 || int_en !== 1'b0 || int_mask !== 8'hFF) begin n_bad++; $display("FAIL midrst_regs epc=%h code=%h en=%b mask=%h", epc, exp_code, int_en, int_mask); end
    idle(); reset = 0;
    @(negedge clk); #1;
    n_cmp++; if ({stalls, flushes} !== 8'h00) begin n_bad++; $display("FAIL midrst_run stall=%h flush=%h want 0", stalls, flushes); end
  endtask

  initial begin
    test_reset();
    test_wrcr();
    test_busy_exception();
    test_exception();
    test_exrt();
    test_ld_hazard();
    test_irq();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
